// File: rtl/fir_n_filter_pkg.sv
// Shared constants and accumulator sizing for the fir_n_filter slice.
package fir_n_filter_pkg;

  localparam int unsigned N_DEF      = 32;
  localparam int unsigned DELAYS_DEF = 3;

  // Width that holds the full-precision sum of (delays+1) products of n-bit operands.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned delays);
    return 2 * n + $clog2(delays + 1);
  endfunction

  typedef logic signed [acc_width(N_DEF, DELAYS_DEF)-1:0] acc_t;

endpackage

// File: rtl/fir_n_filter_sample_strobe_gen.sv
// Divides the system clock down to a one-cycle sample strobe every CLK_HZ/DESIRED_HZ clocks.
module sample_strobe_gen #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned DESIRED_HZ = 48_000
) (
  input  logic clk,
  input  logic rst,
  output logic stb
);

  localparam int unsigned DIV   = CLK_HZ / DESIRED_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Gated by rst so the DIV==1 case stays quiet while reset is held.
  assign stb = (cnt_q == LAST) & ~rst;

endmodule

// File: rtl/fir_n_filter.sv
// Direct-form FIR, DELAYS+1 taps, updated on an internal sample strobe.
// Optional: FIR_N_FILTER_PRINT_IO_EN adds a simulation-only print_io task.
module fir_n_filter
  import fir_n_filter_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned DELAYS     = DELAYS_DEF,
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned DESIRED_HZ = 48_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic signed [N-1:0]        x_in,
  input  logic [(DELAYS+1)*N-1:0]    b,
  output logic signed [N-1:0]        y_out,
  output logic                       sample_stb
);

  localparam int unsigned ACC_W = acc_width(N, DELAYS);

  logic                      upd;
  logic signed [N-1:0]       d_q [DELAYS];
  logic [(DELAYS+1)*N-1:0]   taps;
  logic signed [N-1:0]       y_d;

  sample_strobe_gen #(
    .CLK_HZ    (CLK_HZ),
    .DESIRED_HZ(DESIRED_HZ)
  ) u_stb (
    .clk(clk),
    .rst(rst),
    .stb(sample_stb)
  );

  assign upd = sample_stb & ena & ~rst;

  // taps[k] lines up with coefficient b_k: tap 0 is the live input.
  assign taps[N-1:0] = x_in;

  for (genvar k = 0; k < DELAYS; k++) begin : g_dly
    assign taps[(k+1)*N +: N] = d_q[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        d_q[k] <= '0;
      end else if (upd) begin
        if (k == 0) d_q[k] <= x_in;
        else        d_q[k] <= d_q[(k > 0) ? k-1 : 0];
      end
    end
  end

  function automatic logic signed [N-1:0] mac(
    input logic [(DELAYS+1)*N-1:0] coefs,
    input logic [(DELAYS+1)*N-1:0] t
  );
    logic signed [ACC_W-1:0] acc;
    logic signed [2*N-1:0]   prod;
    acc = '0;
    for (int unsigned k = 0; k <= DELAYS; k++) begin
      prod = $signed(coefs[k*N +: N]) * $signed(t[k*N +: N]);
      acc  = acc + ACC_W'(prod);
    end
    return acc[N-1:0];
  endfunction

  assign y_d = mac(b, taps);

  always_ff @(posedge clk) begin
    if (rst)      y_out <= '0;
    else if (upd) y_out <= y_d;
  end

`ifdef FIR_N_FILTER_PRINT_IO_EN
  task automatic print_io();
    $write("%0t x_in=%0d y_out=%0d d=", $time, x_in, y_out);
    for (int unsigned k = 0; k < DELAYS; k++) $write(" %0d", d_q[k]);
    $write("\n");
  endtask
`else
`endif

endmodule

// File: tb/tb_fir_n_filter.sv
// Directed, table-driven bench for fir_n_filter (DIV=4) plus a DIV=1 strobe instance.
module tb_fir_n_filter;

  localparam int unsigned N = 32;
  localparam int unsigned DELAYS = 3;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         ena = 1'b1;
  logic signed [N-1:0]          x_in = '0;
  logic [(DELAYS+1)*N-1:0]      b = '0;
  logic signed [N-1:0]          y_out;
  logic                         sample_stb;
  logic signed [N-1:0]          y_out1;
  logic                         sample_stb1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_n_filter #(.N(N), .DELAYS(DELAYS), .CLK_HZ(8), .DESIRED_HZ(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .x_in(x_in), .b(b),
    .y_out(y_out), .sample_stb(sample_stb)
  );

  fir_n_filter #(.N(N), .DELAYS(DELAYS), .CLK_HZ(5), .DESIRED_HZ(5)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .x_in(x_in), .b(b),
    .y_out(y_out1), .sample_stb(sample_stb1)
  );

  typedef struct {
    logic signed [31:0] x;
    logic               en;
    logic signed [31:0] y;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Wait for the next strobe, let the update edge pass, sample #1 later.
  task automatic next_sample(input string name);
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sample_stb) begin
        found = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: strobe timeout, got none expected one within 8 clocks", name);
    end
`ifdef FIR_N_FILTER_PRINT_IO_EN
    dut.print_io();
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Impulse 1000 -> 193000, 376000, 376000, 193000, 0, 0
    vecs[0]  = '{1000, 1'b1, 193000};
    vecs[1]  = '{0,    1'b1, 376000};
    vecs[2]  = '{0,    1'b1, 376000};
    vecs[3]  = '{0,    1'b1, 193000};
    vecs[4]  = '{0,    1'b1, 0};
    vecs[5]  = '{0,    1'b1, 0};
    // Step of -1: -193, -569, -945, -1138, steady
    vecs[6]  = '{-1,   1'b1, -193};
    vecs[7]  = '{-1,   1'b1, -569};
    vecs[8]  = '{-1,   1'b1, -945};
    vecs[9]  = '{-1,   1'b1, -1138};
    vecs[10] = '{-1,   1'b1, -1138};
    // Decay with a 3-strobe ena gap; frozen inputs of 5 must be ignored
    vecs[11] = '{0,    1'b1, -945};
    vecs[12] = '{5,    1'b0, -945};
    vecs[13] = '{5,    1'b0, -945};
    vecs[14] = '{5,    1'b0, -945};
    vecs[15] = '{0,    1'b1, -569};
    vecs[16] = '{0,    1'b1, -193};
    vecs[17] = '{0,    1'b1, 0};

    b = {32'sd193, 32'sd376, 32'sd376, 32'sd193};

    // Reset state, including the DIV=1 strobe held low by rst
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_y_out", y_out, 32'd0);
    check("rst_stb", {31'd0, sample_stb}, 32'd0);
    check("rst_stb_div1", {31'd0, sample_stb1}, 32'd0);

    // Strobe cadence: pulses before edges 4, 8, 12 after release, never wider than 1
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("stb_clk%0d", c), {31'd0, sample_stb}, {31'd0, (c % 4) == 0});
      if (c == 2 || c == 7) check($sformatf("stb_div1_clk%0d", c), {31'd0, sample_stb1}, 32'd1);
      @(posedge clk);
      #1;
    end

    // Table: impulse, step, ena gating
    do_reset();
    for (int i = 0; i < 18; i++) begin
      x_in = vecs[i].x;
      ena  = vecs[i].en;
      next_sample($sformatf("vec%0d", i));
      check($sformatf("vec%0d_y", i), y_out, vecs[i].y);
    end
    ena = 1'b1;

    // Reset mid-operation discards history
    do_reset();
    x_in = 1000;
    next_sample("mid_rst_pre");
    check("mid_rst_pre_y", y_out, 32'd193000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_y_cleared", y_out, 32'd0);
    x_in = 0;
    for (int i = 0; i < 4; i++) begin
      next_sample("mid_rst_post");
      check($sformatf("mid_rst_post%0d_y", i), y_out, 32'd0);
    end

    // Wrap: low N bits of 0x7FFFFFFF * 2, no saturation
    b = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    do_reset();
    x_in = 2;
    next_sample("wrap");
    check("wrap_y", y_out, 32'hFFFF_FFFE);
    // Between strobes y_out must hold
    @(posedge clk);
    #1;
    check("wrap_hold_y", y_out, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
